// File: rtl/e203_thread_ctx_swap_if.sv
// Context-switch handshake bundle between the switch controller, front-end,
// pipeline and ifetch on one side and the context-swap responder on the other.
interface e203_thread_ctx_swap_if #(
  parameter int THREADS_NUM = 2,
  parameter int PC_SIZE     = 32,
  parameter int CNT_W       = 16
);
  logic                   sw_req_valid;
  logic [THREADS_NUM-1:0] sw_req_thread;
  logic                   sw_req_ready;
  logic                   flush_req;
  logic                   flush_ack;
  logic                   pipe_empty;
  logic [PC_SIZE-1:0]     cur_pc;
  logic                   redir_valid;
  logic [PC_SIZE-1:0]     redir_pc;
  logic                   redir_ready;
  logic [THREADS_NUM-1:0] thread_active;
  logic                   busy;
  logic                   sw_done;
  logic [CNT_W-1:0]       sw_count;

  modport slave (
    input  sw_req_valid, sw_req_thread, flush_ack, pipe_empty, cur_pc, redir_ready,
    output sw_req_ready, flush_req, redir_valid, redir_pc, thread_active, busy,
           sw_done, sw_count
  );

  modport master (
    output sw_req_valid, sw_req_thread, flush_ack, pipe_empty, cur_pc, redir_ready,
    input  sw_req_ready, flush_req, redir_valid, redir_pc, thread_active, busy,
           sw_done, sw_count
  );
endinterface

// File: rtl/e203_thread_ctx_swap.sv
// Responder for thread context switches: flush, drain, save outgoing PC,
// restore incoming PC, redirect fetch and update the active-thread vector.
//
// state | meaning
// IDLE  | ready for a switch request; no-op and invalid requests handled here
// FLUSH | flush_req asserted until the front-end acknowledges
// DRAIN | waiting for pipe_empty; bank swap and thread_active update on exit
// REDIR | redir_valid asserted with a stable redir_pc until ifetch accepts
module e203_thread_ctx_swap #(
  parameter int                THREADS_NUM = 2,
  parameter int                PC_SIZE     = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC0  = 32'h8000_0000,
  parameter logic [PC_SIZE-1:0] RESET_PC1  = 32'h8000_1000,
  parameter int                CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst,
  e203_thread_ctx_swap_if.slave ctx
);

  localparam int IDX_W = (THREADS_NUM > 1) ? $clog2(THREADS_NUM) : 1;
  localparam logic [THREADS_NUM-1:0] ACTIVE_RST = THREADS_NUM'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [THREADS_NUM-1:0] tgt_q, tgt_d;
  logic [THREADS_NUM-1:0] src_q, src_d;
  logic [THREADS_NUM-1:0] active_q, active_d;
  logic                   flush_q, flush_d;
  logic                   redir_valid_q, redir_valid_d;
  logic [PC_SIZE-1:0]     redir_pc_q, redir_pc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   bank_we;
  logic [PC_SIZE-1:0]     bank [THREADS_NUM];
  logic                   req_onehot;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [THREADS_NUM-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < THREADS_NUM; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [PC_SIZE-1:0] reset_pc(input int i);
    return (i == 1) ? RESET_PC1 : RESET_PC0;
  endfunction

  assign req_onehot = (ctx.sw_req_thread != '0) &&
                      ((ctx.sw_req_thread & (ctx.sw_req_thread - THREADS_NUM'(1))) == '0);

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    src_d         = src_q;
    active_d      = active_q;
    flush_d       = 1'b0;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    done_d        = 1'b0;
    count_d       = count_q;
    bank_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctx.sw_req_valid) begin
          if (ctx.sw_req_thread == active_q) begin
            done_d = 1'b1;
          end else if (req_onehot) begin
            state_d = FLUSH;
            tgt_d   = ctx.sw_req_thread;
            src_d   = active_q;
            flush_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (ctx.flush_ack) begin
          state_d = DRAIN;
        end else begin
          flush_d = 1'b1;
        end
      end
      DRAIN: begin
        if (ctx.pipe_empty) begin
          // tgt and src differ, so the save and restore never hit the same entry
          bank_we       = 1'b1;
          redir_pc_d    = bank[oh2idx(tgt_q)];
          active_d      = tgt_q;
          redir_valid_d = 1'b1;
          state_d       = REDIR;
        end
      end
      REDIR: begin
        if (ctx.redir_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
          count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        end else begin
          redir_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tgt_q         <= ACTIVE_RST;
      src_q         <= ACTIVE_RST;
      active_q      <= ACTIVE_RST;
      flush_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      count_q       <= '0;
      for (int i = 0; i < THREADS_NUM; i++) begin
        bank[i] <= reset_pc(i);
      end
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      src_q         <= src_d;
      active_q      <= active_d;
      flush_q       <= flush_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      count_q       <= count_d;
      if (bank_we) begin
        bank[oh2idx(src_q)] <= ctx.cur_pc;
      end
    end
  end

  assign ctx.sw_req_ready  = (state_q == IDLE);
  assign ctx.flush_req     = flush_q;
  assign ctx.redir_valid   = redir_valid_q;
  assign ctx.redir_pc      = redir_pc_q;
  assign ctx.thread_active = active_q;
  assign ctx.busy          = busy_q;
  assign ctx.sw_done       = done_q;
  assign ctx.sw_count      = count_q;

endmodule

// File: tb/tb_e203_thread_ctx_swap.sv
// Directed bench for the context-swap responder; the counter is built narrow
// so its saturation can be reached in a short run.
module tb_e203_thread_ctx_swap;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   exp_count;
  logic [1:0]  cur_active;
  logic [31:0] mdl_bank [2];

  e203_thread_ctx_swap_if #(.THREADS_NUM(2), .PC_SIZE(32), .CNT_W(CNT_W)) ctx ();

  e203_thread_ctx_swap #(
    .THREADS_NUM(2),
    .PC_SIZE(32),
    .RESET_PC0(32'h8000_0000),
    .RESET_PC1(32'h8000_1000),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctx(ctx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [1:0] oh);
    return (oh == 2'b10) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mdl_bank[0] = 32'h8000_0000;
    mdl_bank[1] = 32'h8000_1000;
    exp_count   = 0;
    cur_active  = 2'b01;
  endtask

  // Full switch with every handshake delayed by d cycles; with hold the request
  // stays asserted and the task returns in the sw_done cycle.
  task automatic do_switch(input logic [1:0] tgt, input logic [31:0] pc, input int d,
                           input logic [31:0] exp_pc, input bit hold);
    logic [1:0] src;
    src = cur_active;
    ctx.sw_req_valid  = 1'b1;
    ctx.sw_req_thread = tgt;
    check("req_ready_idle", ctx.sw_req_ready, 1);
    tick();
    if (!hold) ctx.sw_req_valid = 1'b0;
    check("flush_req_on", ctx.flush_req, 1);
    check("busy_on", ctx.busy, 1);
    check("req_ready_busy", ctx.sw_req_ready, 0);
    ctx.redir_ready = 1'b1;
    for (int i = 0; i < d; i++) begin
      tick();
      check("flush_req_hold", ctx.flush_req, 1);
      check("redir_valid_in_flush", ctx.redir_valid, 0);
    end
    ctx.flush_ack   = 1'b1;
    ctx.redir_ready = 1'b0;
    ctx.pipe_empty  = (d == 0);
    ctx.cur_pc      = pc;
    tick();
    ctx.flush_ack = 1'b0;
    check("flush_req_drop", ctx.flush_req, 0);
    check("active_in_drain", ctx.thread_active, src);
    for (int i = 0; i < d; i++) begin
      tick();
      check("active_drain_wait", ctx.thread_active, src);
      check("redir_valid_drain", ctx.redir_valid, 0);
    end
    ctx.pipe_empty = 1'b1;
    tick();
    ctx.pipe_empty = 1'b0;
    ctx.cur_pc     = 32'hdead_beef;
    check("redir_valid_on", ctx.redir_valid, 1);
    check("redir_pc", ctx.redir_pc, exp_pc);
    check("active_tgt", ctx.thread_active, tgt);
    for (int i = 0; i < d; i++) begin
      tick();
      check("redir_pc_hold", ctx.redir_pc, exp_pc);
      check("redir_valid_hold", ctx.redir_valid, 1);
    end
    ctx.redir_ready = 1'b1;
    tick();
    ctx.redir_ready = 1'b0;
    mdl_bank[idx(src)] = pc;
    cur_active = tgt;
    exp_count  = (exp_count == CNT_MAX) ? CNT_MAX : exp_count + 1;
    check("sw_done_pulse", ctx.sw_done, 1);
    check("busy_off", ctx.busy, 0);
    check("redir_valid_off", ctx.redir_valid, 0);
    check("sw_count", ctx.sw_count, exp_count);
    check("req_ready_done", ctx.sw_req_ready, 1);
    if (!hold) begin
      tick();
      check("sw_done_single", ctx.sw_done, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_active"}, ctx.thread_active, 2'b01);
    check({tag, "_busy"}, ctx.busy, 0);
    check({tag, "_ready"}, ctx.sw_req_ready, 1);
    check({tag, "_flush"}, ctx.flush_req, 0);
    check({tag, "_rvalid"}, ctx.redir_valid, 0);
    check({tag, "_rpc"}, ctx.redir_pc, 0);
    check({tag, "_done"}, ctx.sw_done, 0);
    check({tag, "_count"}, ctx.sw_count, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst = 1'b1;
    ctx.sw_req_valid  = 1'b0;
    ctx.sw_req_thread = 2'b00;
    ctx.flush_ack     = 1'b0;
    ctx.pipe_empty    = 1'b0;
    ctx.cur_pc        = '0;
    ctx.redir_ready   = 1'b0;
    tick();
    tick();
    check_reset_outputs("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_reset_outputs("idle");
    end

    // single switch, then switch back with slow handshakes, then a third to read bank[1]
    do_switch(2'b10, 32'h8000_0124, 0, 32'h8000_1000, 1'b0);
    do_switch(2'b01, 32'h8000_1010, 3, 32'h8000_0124, 1'b0);
    do_switch(2'b10, 32'h8000_0200, 0, 32'h8000_1010, 1'b0);

    // degenerate requests while thread 1 is active
    ctx.sw_req_valid  = 1'b1;
    ctx.sw_req_thread = 2'b10;
    tick();
    ctx.sw_req_valid = 1'b0;
    check("noop_done", ctx.sw_done, 1);
    check("noop_busy", ctx.busy, 0);
    check("noop_flush", ctx.flush_req, 0);
    check("noop_count", ctx.sw_count, 3);
    tick();
    check("noop_done_single", ctx.sw_done, 0);
    check("noop_flush_after", ctx.flush_req, 0);
    ctx.sw_req_valid  = 1'b1;
    ctx.sw_req_thread = 2'b00;
    tick();
    ctx.sw_req_thread = 2'b11;
    check("zero_done", ctx.sw_done, 0);
    check("zero_busy", ctx.busy, 0);
    tick();
    ctx.sw_req_valid = 1'b0;
    check("multi_done", ctx.sw_done, 0);
    check("multi_flush", ctx.flush_req, 0);
    check("multi_active", ctx.thread_active, 2'b10);
    tick();
    check("drop_ready", ctx.sw_req_ready, 1);
    check("drop_count", ctx.sw_count, 3);

    // reset during DRAIN
    ctx.sw_req_valid  = 1'b1;
    ctx.sw_req_thread = 2'b01;
    tick();
    ctx.sw_req_valid = 1'b0;
    ctx.flush_ack    = 1'b1;
    tick();
    ctx.flush_ack = 1'b0;
    check("pre_rst_drain_busy", ctx.busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_drain");
    tick();
    rst = 1'b0;
    model_reset();
    tick();

    // reset during REDIR
    ctx.sw_req_valid  = 1'b1;
    ctx.sw_req_thread = 2'b10;
    tick();
    ctx.sw_req_valid = 1'b0;
    ctx.flush_ack    = 1'b1;
    tick();
    ctx.flush_ack  = 1'b0;
    ctx.pipe_empty = 1'b1;
    ctx.cur_pc     = 32'h8000_0333;
    tick();
    ctx.pipe_empty = 1'b0;
    check("pre_rst_redir_valid", ctx.redir_valid, 1);
    check("pre_rst_redir_active", ctx.thread_active, 2'b10);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_redir");
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    do_switch(2'b10, 32'h8000_0444, 0, 32'h8000_1000, 1'b0);

    // request held high across a switch, second accepted in the sw_done cycle
    do_switch(2'b01, 32'h8000_0555, 1, 32'h8000_0444, 1'b1);
    ctx.sw_req_thread = 2'b10;
    do_switch(2'b10, 32'h8000_0666, 0, 32'h8000_0555, 1'b0);
    check("held_total_count", ctx.sw_count, 3);

    // drive the counter to saturation and beyond
    while (exp_count < CNT_MAX) begin
      do_switch(~cur_active, 32'h8000_0700 + 32'(exp_count), 0, mdl_bank[idx(~cur_active)], 1'b0);
    end
    check("count_at_max", ctx.sw_count, CNT_MAX);
    do_switch(~cur_active, 32'h8000_0800, 0, mdl_bank[idx(~cur_active)], 1'b0);
    check("count_saturated", ctx.sw_count, CNT_MAX);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
